// File: rtl/dcntr.sv
// Loadable down-counter / interval timer with a one-cycle terminal-count pulse.
// Optional feature macro: DCNTR_AUTORELOAD_EN (periodic reload instead of one-shot).
module dcntr #(
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] load_val,
  input  logic                   en,
  input  logic                   abort,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_busy;
  logic                   r_tc;
`ifdef DCNTR_AUTORELOAD_EN
  logic [COUNT_WIDTH-1:0] r_reload;
`endif

  logic w_load_zero;
  logic w_at_one;

  assign w_load_zero = (load_val == '0);
  assign w_at_one    = (r_count == COUNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_tc     <= 1'b0;
`ifdef DCNTR_AUTORELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_tc <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_load_zero) begin
              // Zero-length interval: immediate terminal pulse, never enters RUN.
              r_tc <= 1'b1;
            end else begin
              r_count <= load_val;
              r_busy  <= 1'b1;
              r_state <= RUN;
`ifdef DCNTR_AUTORELOAD_EN
              r_reload <= load_val;
`endif
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_count <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (en) begin
            if (w_at_one) begin
              r_tc <= 1'b1;
`ifdef DCNTR_AUTORELOAD_EN
              r_count <= r_reload;
`else
              r_count <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
`endif
            end else begin
              r_count <= r_count - COUNT_WIDTH'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign tc    = r_tc;

endmodule

// File: tb/tb_dcntr.sv
// Directed self-checking bench for dcntr (COUNT_WIDTH=4).
// Build with DCNTR_AUTORELOAD_EN defined to exercise the periodic-reload variant.
module tb_dcntr;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] load_val;
  logic       en;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       tc;

  int n_checks;
  int n_errors;

  dcntr #(.COUNT_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [3:0] c, input logic b, input logic t);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".tc"},    32'(tc),    32'(t));
    $display("%0t %s count=%0d busy=%0b tc=%0b", $time, tag, count, busy, tc);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    load_val = 4'd0;
    en       = 1'b0;
    abort    = 1'b0;
    step();
    step();
    chk3("reset", 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk3("idle", 4'd0, 1'b0, 1'b0);

    abort = 1'b1;
    step();
    chk3("abort_idle", 4'd0, 1'b0, 1'b0);
    abort = 1'b0;

`ifndef DCNTR_AUTORELOAD_EN
    // Load 5, free-running decrement.
    start = 1'b1; load_val = 4'd5; en = 1'b1;
    step();
    chk3("t1_load", 4'd5, 1'b1, 1'b0);
    start = 1'b0;
    step(); chk3("t1_c4", 4'd4, 1'b1, 1'b0);
    step(); chk3("t1_c3", 4'd3, 1'b1, 1'b0);
    step(); chk3("t1_c2", 4'd2, 1'b1, 1'b0);
    step(); chk3("t1_c1", 4'd1, 1'b1, 1'b0);
    step(); chk3("t1_tc", 4'd0, 1'b0, 1'b1);
    step(); chk3("t1_after", 4'd0, 1'b0, 1'b0);

    // Load 3 with two stalled cycles at count=2.
    start = 1'b1; load_val = 4'd3; en = 1'b1;
    step(); chk3("t2_load", 4'd3, 1'b1, 1'b0);
    start = 1'b0;
    step(); chk3("t2_c2", 4'd2, 1'b1, 1'b0);
    en = 1'b0;
    step(); chk3("t2_hold1", 4'd2, 1'b1, 1'b0);
    step(); chk3("t2_hold2", 4'd2, 1'b1, 1'b0);
    en = 1'b1;
    step(); chk3("t2_c1", 4'd1, 1'b1, 1'b0);
    step(); chk3("t2_tc", 4'd0, 1'b0, 1'b1);

    // Restart accepted while tc is high: zero-load pulse, then back-to-back load 2.
    start = 1'b1; load_val = 4'd0;
    step(); chk3("t3_zero", 4'd0, 1'b0, 1'b1);
    load_val = 4'd2;
    step(); chk3("t3_b2b", 4'd2, 1'b1, 1'b0);
    start = 1'b0;
    step(); chk3("t3_c1", 4'd1, 1'b1, 1'b0);
    step(); chk3("t3_tc", 4'd0, 1'b0, 1'b1);

    // Load 9, start pulses ignored during RUN, abort at count=4.
    start = 1'b1; load_val = 4'd9;
    step(); chk3("t4_load", 4'd9, 1'b1, 1'b0);
    load_val = 4'd15;
    step(); chk3("t4_ign8", 4'd8, 1'b1, 1'b0);
    start = 1'b0;
    step(); step(); step();
    chk3("t4_c5", 4'd5, 1'b1, 1'b0);
    start = 1'b1;
    step(); chk3("t4_c4", 4'd4, 1'b1, 1'b0);
    start = 1'b0; abort = 1'b1;
    step(); chk3("t4_abort", 4'd0, 1'b0, 1'b0);
    abort = 1'b0;
    step(); chk3("t4_no_tc", 4'd0, 1'b0, 1'b0);

    // Max load runs 15 enabled cycles.
    start = 1'b1; load_val = 4'd15;
    step(); chk3("t6_load", 4'd15, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk3("t6_c2", 4'd2, 1'b1, 1'b0);
    step(); chk3("t6_c1", 4'd1, 1'b1, 1'b0);
    step(); chk3("t6_tc", 4'd0, 1'b0, 1'b1);
`else
    // Periodic reload with value 2.
    start = 1'b1; load_val = 4'd2; en = 1'b1;
    step(); chk3("ar_load", 4'd2, 1'b1, 1'b0);
    start = 1'b0;
    step(); chk3("ar_c1a", 4'd1, 1'b1, 1'b0);
    step(); chk3("ar_rl1", 4'd2, 1'b1, 1'b1);
    step(); chk3("ar_c1b", 4'd1, 1'b1, 1'b0);
    step(); chk3("ar_rl2", 4'd2, 1'b1, 1'b1);
    abort = 1'b1;
    step(); chk3("ar_abort", 4'd0, 1'b0, 1'b0);
    abort = 1'b0;
    start = 1'b1; load_val = 4'd0;
    step(); chk3("ar_zero", 4'd0, 1'b0, 1'b1);
    start = 1'b0;
`endif

    // Asynchronous reset mid-RUN clears state before the next edge.
    start = 1'b1; load_val = 4'd7; en = 1'b1;
    step(); chk3("t5_load", 4'd7, 1'b1, 1'b0);
    start = 1'b0;
    step(); chk3("t5_c6", 4'd6, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk3("t5_async", 4'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step(); chk3("t5_idle", 4'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
